// File: rtl/control_unit_pkg.sv
// Shared definitions for the cs147sec05 control unit: opcodes, ALU codes, states, CTRL bit map.
package control_unit_pkg;

  localparam int CTRL_W      = 32;
  localparam bit ILLEGAL_NOP = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_MULI = 6'h1d, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_SLTI = 6'h0a, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_LW   = 6'h23, OP_SW   = 6'h2b, OP_JMP  = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03, OP_PUSH = 6'h1b, OP_POP  = 6'h1c;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_MUL = 6'h2c, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02, FN_JR  = 6'h08;

  localparam logic [5:0] ALU_ADD = 6'h01, ALU_SUB = 6'h02, ALU_MUL = 6'h03, ALU_SHR = 6'h04;
  localparam logic [5:0] ALU_SHL = 6'h05, ALU_AND = 6'h06, ALU_OR  = 6'h07, ALU_NOR = 6'h08;
  localparam logic [5:0] ALU_SLT = 6'h09;

  localparam int CTRL_PC_LOAD = 0, CTRL_PC_SEL_LSB = 1, CTRL_IR_LOAD = 4, CTRL_SP_LOAD = 5;
  localparam int CTRL_REG_R   = 6, CTRL_REG_W = 7, CTRL_OP1_SEL = 8, CTRL_OP2_LSB = 9;
  localparam int CTRL_WD_LSB  = 13, CTRL_R1_SEL = 16, CTRL_WA_LSB = 17, CTRL_MA_LSB = 20;
  localparam int CTRL_MD_SEL  = 22, CTRL_ALU_LSB = 26;

  typedef enum logic [4:0] {
    I_ILL, I_ADD, I_SUB, I_MUL, I_AND, I_OR, I_NOR, I_SLT, I_SHL, I_SHR, I_JR,
    I_ADDI, I_MULI, I_ANDI, I_ORI, I_LUI, I_SLTI, I_BEQ, I_BNE, I_LW, I_SW,
    I_JMP, I_JAL, I_PUSH, I_POP
  } instr_t;

  function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
    instr_t r;
    r = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  r = I_ADD;
          FN_SUB:  r = I_SUB;
          FN_MUL:  r = I_MUL;
          FN_AND:  r = I_AND;
          FN_OR:   r = I_OR;
          FN_NOR:  r = I_NOR;
          FN_SLT:  r = I_SLT;
          FN_SLL:  r = I_SHL;
          FN_SRL:  r = I_SHR;
          FN_JR:   r = I_JR;
          default: r = I_ILL;
        endcase
      end
      OP_ADDI: r = I_ADDI;
      OP_MULI: r = I_MULI;
      OP_ANDI: r = I_ANDI;
      OP_ORI:  r = I_ORI;
      OP_LUI:  r = I_LUI;
      OP_SLTI: r = I_SLTI;
      OP_BEQ:  r = I_BEQ;
      OP_BNE:  r = I_BNE;
      OP_LW:   r = I_LW;
      OP_SW:   r = I_SW;
      OP_JMP:  r = I_JMP;
      OP_JAL:  r = I_JAL;
      OP_PUSH: r = I_PUSH;
      OP_POP:  r = I_POP;
      default: r = I_ILL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit (master) and the datapath/memory side (slave).
interface control_unit_if;
  logic [31:0]                       INSTRUCTION;
  logic                              ZERO;
  logic [control_unit_pkg::CTRL_W-1:0] CTRL;
  logic                              READ;
  logic                              WRITE;

  modport master (input INSTRUCTION, ZERO, output CTRL, READ, WRITE);
  modport slave  (output INSTRUCTION, ZERO, input CTRL, READ, WRITE);
endinterface

// File: rtl/control_unit_decode.sv
// Combinational decode of (state, IR copy, branch flag) into CTRL, READ and WRITE.
module control_word_decode
  import control_unit_pkg::*;
(
  input  state_t              i_state,
  input  logic [31:0]         i_ir,
  input  logic                i_br_flag,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic                o_read,
  output logic                o_write
);
  instr_t            w_ins;
  logic [5:0]        w_alu;
  logic              w_op1, w_r1, w_regw, w_kill, w_read, w_write;
  logic [3:0]        w_op2;
  logic [2:0]        w_wa, w_wd, w_pc;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_unused_fields;

  assign w_ins           = classify(i_ir[31:26], i_ir[5:0]);
  assign w_kill          = ILLEGAL_NOP && (w_ins == I_ILL);
  assign w_unused_fields = ^i_ir[25:6];

  // operand/ALU group, driven from EXE through WB
  always_comb begin
    w_alu = '0; w_op1 = 1'b0; w_op2 = '0; w_r1 = 1'b0;
    case (w_ins)
      I_ADD:             begin w_alu = ALU_ADD; w_op2 = 4'b1000; end
      I_SUB:             begin w_alu = ALU_SUB; w_op2 = 4'b1000; end
      I_MUL:             begin w_alu = ALU_MUL; w_op2 = 4'b1000; end
      I_AND:             begin w_alu = ALU_AND; w_op2 = 4'b1000; end
      I_OR:              begin w_alu = ALU_OR;  w_op2 = 4'b1000; end
      I_NOR:             begin w_alu = ALU_NOR; w_op2 = 4'b1000; end
      I_SLT:             begin w_alu = ALU_SLT; w_op2 = 4'b1000; end
      I_SHR:             begin w_alu = ALU_SHR; w_op2 = 4'b0101; end
      I_SHL:             begin w_alu = ALU_SHL; w_op2 = 4'b0101; end
      I_ADDI, I_LW, I_SW: begin w_alu = ALU_ADD; w_op2 = 4'b0010; end
      I_MULI:            begin w_alu = ALU_MUL; w_op2 = 4'b0010; end
      I_SLTI:            begin w_alu = ALU_SLT; w_op2 = 4'b0010; end
      I_ANDI:            w_alu = ALU_AND;
      I_ORI:             w_alu = ALU_OR;
      I_BEQ, I_BNE:      begin w_alu = ALU_SUB; w_op2 = 4'b1000; end
      I_PUSH:            begin w_alu = ALU_SUB; w_op1 = 1'b1; w_op2 = 4'b0100; w_r1 = 1'b1; end
      I_POP:             begin w_alu = ALU_ADD; w_op1 = 1'b1; w_op2 = 4'b0100; end
      default:           ;
    endcase
  end

  always_comb begin
    w_regw = 1'b0; w_wa = '0; w_wd = '0; w_pc = 3'b101;
    case (w_ins)
      I_ADD, I_SUB, I_MUL, I_AND, I_OR, I_NOR, I_SLT, I_SHL, I_SHR:
        begin w_regw = 1'b1; w_wa = 3'b100; w_wd = 3'b100; end
      I_ADDI, I_MULI, I_ANDI, I_ORI, I_SLTI:
        begin w_regw = 1'b1; w_wa = 3'b101; w_wd = 3'b100; end
      I_LUI:        begin w_regw = 1'b1; w_wa = 3'b101; w_wd = 3'b110; end
      I_LW:         begin w_regw = 1'b1; w_wa = 3'b101; w_wd = 3'b101; end
      I_POP:        begin w_regw = 1'b1; w_wa = 3'b000; w_wd = 3'b101; end
      I_JAL:        begin w_regw = 1'b1; w_wa = 3'b010; w_wd = 3'b000; w_pc = 3'b001; end
      I_JMP:        w_pc = 3'b001;
      I_JR:         w_pc = 3'b100;
      I_BEQ, I_BNE: w_pc[1] = i_br_flag;
      default:      ;
    endcase
  end

  always_comb begin
    w_ctrl = '0; w_read = 1'b0; w_write = 1'b0;
    case (i_state)
      S_FETCH: begin
        w_read                   = 1'b1;
        w_ctrl[CTRL_IR_LOAD]     = 1'b1;
        w_ctrl[CTRL_MA_LSB + 1]  = 1'b1;
      end
      S_DECODE: begin
        w_ctrl[CTRL_REG_R]  = 1'b1;
        w_ctrl[CTRL_R1_SEL] = (w_ins == I_PUSH);
      end
      S_EXE, S_MEM, S_WB: begin
        w_ctrl[CTRL_ALU_LSB +: 6] = w_alu;
        w_ctrl[CTRL_OP1_SEL]      = w_op1;
        w_ctrl[CTRL_OP2_LSB +: 4] = w_op2;
        w_ctrl[CTRL_R1_SEL]       = w_r1;
        if (i_state == S_EXE) begin
          w_ctrl[CTRL_REG_R]   = 1'b1;
          w_ctrl[CTRL_SP_LOAD] = (w_ins == I_POP);
        end else if (i_state == S_MEM) begin
          case (w_ins)
            I_LW:    w_read = 1'b1;
            I_SW:    w_write = 1'b1;
            I_PUSH:  begin w_write = 1'b1; w_ctrl[CTRL_MA_LSB] = 1'b1; w_ctrl[CTRL_MD_SEL] = 1'b1; end
            I_POP:   begin w_read = 1'b1; w_ctrl[CTRL_MA_LSB] = 1'b1; end
            default: ;
          endcase
        end else begin
          w_ctrl[CTRL_PC_LOAD]         = 1'b1;
          w_ctrl[CTRL_PC_SEL_LSB +: 3] = w_pc;
          w_ctrl[CTRL_REG_W]           = w_regw;
          w_ctrl[CTRL_WA_LSB +: 3]     = w_wa;
          w_ctrl[CTRL_WD_LSB +: 3]     = w_wd;
          w_ctrl[CTRL_SP_LOAD]         = (w_ins == I_PUSH);
        end
      end
      default: ;
    endcase
  end

  // unknown encodings must never write architectural state
  always_comb begin
    o_ctrl  = w_ctrl;
    o_read  = w_read;
    o_write = w_write;
    if (w_kill) begin
      o_ctrl[CTRL_REG_W]   = 1'b0;
      o_ctrl[CTRL_SP_LOAD] = 1'b0;
      o_write              = 1'b0;
    end
  end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: state register, IR copy and branch flag; CTRL comes from control_word_decode.
// state  | meaning
// IDLE   | after reset, all outputs low
// FETCH  | read instruction at PC, IR copy loads on exit
// DECODE | register file read
// EXE    | ALU operation, branch flag captured on exit
// MEM    | data memory / stack access
// WB     | register write-back and PC update
module control_unit
  import control_unit_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  control_unit_if.master bus
);
  state_t      r_state, w_state_nxt;
  logic [31:0] r_ir;
  logic        r_br_flag;
  instr_t      w_ins;
  logic        w_br_nxt;

  assign w_ins    = classify(r_ir[31:26], r_ir[5:0]);
  assign w_br_nxt = (w_ins == I_BEQ) ? bus.ZERO : (w_ins == I_BNE) ? ~bus.ZERO : 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_br_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH) r_ir <= bus.INSTRUCTION;
      if (r_state == S_EXE)   r_br_flag <= w_br_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXE;
      S_EXE:    w_state_nxt = S_MEM;
      S_MEM:    w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  control_word_decode u_decode (
    .i_state   (r_state),
    .i_ir      (r_ir),
    .i_br_flag (r_br_flag),
    .o_ctrl    (bus.CTRL),
    .o_read    (bus.READ),
    .o_write   (bus.WRITE)
  );
endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized instruction streams against a mnemonic-level model of the control word.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit dut (.CLK(clk), .RST(rst), .bus(bus));

  function automatic string mnem(input logic [31:0] ir);
    string m;
    m = "ill";
    case (ir[31:26])
      6'h00: case (ir[5:0])
        6'h20: m = "add";  6'h22: m = "sub"; 6'h2c: m = "mul"; 6'h24: m = "and";
        6'h25: m = "or";   6'h27: m = "nor"; 6'h2a: m = "slt"; 6'h01: m = "sll";
        6'h02: m = "srl";  6'h08: m = "jr";  default: m = "ill";
      endcase
      6'h08: m = "addi"; 6'h1d: m = "muli"; 6'h0c: m = "andi"; 6'h0d: m = "ori";
      6'h0f: m = "lui";  6'h0a: m = "slti"; 6'h04: m = "beq";  6'h05: m = "bne";
      6'h23: m = "lw";   6'h2b: m = "sw";   6'h02: m = "jmp";  6'h03: m = "jal";
      6'h1b: m = "push"; 6'h1c: m = "pop";
      default: m = "ill";
    endcase
    return m;
  endfunction

  // phase: 0 idle, 1 fetch, 2 decode, 3 exe, 4 mem, 5 wb; returns {READ, WRITE, CTRL}
  function automatic logic [33:0] model(input int ph, input logic [31:0] ir, input logic br);
    string m;
    logic [31:0] c;
    logic rd, wr, op1, r1, regw;
    logic [5:0] alu;
    logic [3:0] op2;
    logic [2:0] wa, wd, pc;
    m = mnem(ir);
    c = '0; rd = 0; wr = 0; alu = 0; op1 = 0; r1 = 0; op2 = 0;
    case (m)
      "add": begin alu = 1; op2 = 4'b1000; end
      "sub": begin alu = 2; op2 = 4'b1000; end
      "mul": begin alu = 3; op2 = 4'b1000; end
      "and": begin alu = 6; op2 = 4'b1000; end
      "or":  begin alu = 7; op2 = 4'b1000; end
      "nor": begin alu = 8; op2 = 4'b1000; end
      "slt": begin alu = 9; op2 = 4'b1000; end
      "srl": begin alu = 4; op2 = 4'b0101; end
      "sll": begin alu = 5; op2 = 4'b0101; end
      "addi", "lw", "sw": begin alu = 1; op2 = 4'b0010; end
      "muli": begin alu = 3; op2 = 4'b0010; end
      "slti": begin alu = 9; op2 = 4'b0010; end
      "andi": alu = 6;
      "ori":  alu = 7;
      "beq", "bne": begin alu = 2; op2 = 4'b1000; end
      "push": begin alu = 2; op1 = 1; op2 = 4'b0100; r1 = 1; end
      "pop":  begin alu = 1; op1 = 1; op2 = 4'b0100; end
      default: ;
    endcase
    regw = 1; wa = 3'b101; wd = 3'b100; pc = 3'b101;
    case (m)
      "add", "sub", "mul", "and", "or", "nor", "slt", "sll", "srl": wa = 3'b100;
      "addi", "muli", "andi", "ori", "slti": ;
      "lui": wd = 3'b110;
      "lw":  wd = 3'b101;
      "pop": begin wa = 3'b000; wd = 3'b101; end
      "jal": begin wa = 3'b010; wd = 3'b000; pc = 3'b001; end
      "jr":  begin regw = 0; pc = 3'b100; end
      "jmp": begin regw = 0; pc = 3'b001; end
      default: regw = 0;
    endcase
    if (!regw) begin wa = 0; wd = 0; end
    if (br) pc[1] = 1'b1;
    case (ph)
      1: begin rd = 1; c[4] = 1; c[21] = 1; end
      2: begin c[6] = 1; c[16] = (m == "push"); end
      3, 4, 5: begin
        c[31:26] = alu; c[8] = op1; c[12:9] = op2; c[16] = r1;
        if (ph == 3) begin c[6] = 1; c[5] = (m == "pop"); end
        if (ph == 4) begin
          if (m == "lw") rd = 1;
          if (m == "sw") wr = 1;
          if (m == "push") begin wr = 1; c[20] = 1; c[22] = 1; end
          if (m == "pop") begin rd = 1; c[20] = 1; end
        end
        if (ph == 5) begin
          c[0] = 1; c[3:1] = pc; c[7] = regw; c[19:17] = wa; c[15:13] = wd;
          c[5] = (m == "push");
        end
      end
      default: ;
    endcase
    return {rd, wr, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [33:0] exp);
    logic [33:0] got;
    got = {bus.READ, bus.WRITE, bus.CTRL};
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got read/write/ctrl=%b/%b/%h, want %b/%b/%h",
             tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // enters in FETCH and leaves in the next FETCH
  task automatic run_instr(input logic [31:0] ir, input logic z, input bit rst_in_mem);
    string m;
    logic  br;
    m = mnem(ir);
    bus.INSTRUCTION = ir;
    chk({m, "/FETCH"}, model(1, ir, 1'b0));
    tick();
    bus.INSTRUCTION = $urandom();
    chk({m, "/DECODE"}, model(2, ir, 1'b0));
    tick();
    bus.ZERO = z;
    chk({m, "/EXE"}, model(3, ir, 1'b0));
    br = ((m == "beq") && z) || ((m == "bne") && !z);
    tick();
    bus.ZERO = 1'($urandom_range(0, 1));
    chk({m, "/MEM"}, model(4, ir, br));
    if (rst_in_mem) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk({m, "/reset_from_MEM"}, model(0, ir, 1'b0));
      tick();
    end else begin
      tick();
      chk({m, "/WB"}, model(5, ir, br));
      tick();
    end
  endtask

  logic [11:0] tbl [26] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2c}, {6'h00, 6'h24}, {6'h00, 6'h25},
    {6'h00, 6'h27}, {6'h00, 6'h2a}, {6'h00, 6'h01}, {6'h00, 6'h02}, {6'h00, 6'h08},
    {6'h08, 6'h00}, {6'h1d, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00}, {6'h0f, 6'h00},
    {6'h0a, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
    {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h1b, 6'h00}, {6'h1c, 6'h00}, {6'h3f, 6'h00},
    {6'h00, 6'h3f}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ir;
    logic [11:0] e;
    rst = 1'b1;
    bus.INSTRUCTION = '0;
    bus.ZERO = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset/IDLE", 34'h0);
    tick();

    run_instr(32'h00221820, 1'b0, 0);  // add r3,r1,r2
    run_instr(32'h10220005, 1'b1, 0);  // beq taken
    run_instr(32'h10220005, 1'b0, 0);  // beq not taken
    run_instr(32'h14220005, 1'b0, 0);  // bne taken
    run_instr(32'h14220005, 1'b1, 0);  // bne not taken
    run_instr(32'h8C220004, 1'b0, 0);  // lw
    run_instr(32'hAC220004, 1'b0, 0);  // sw
    run_instr(32'h6C000000, 1'b0, 0);  // push
    run_instr(32'h70000000, 1'b0, 0);  // pop
    run_instr(32'h0C000100, 1'b0, 0);  // jal
    run_instr(32'h08000100, 1'b0, 0);  // jmp
    run_instr(32'h03E00008, 1'b0, 0);  // jr r31
    run_instr(32'h00221041, 1'b0, 0);  // sll
    run_instr(32'h3C01ABCD, 1'b0, 0);  // lui
    run_instr(32'hFC000000, 1'b1, 0);  // illegal opcode
    run_instr(32'h0000003F, 1'b0, 0);  // illegal funct
    run_instr(32'hAC220004, 1'b0, 1);  // sw abandoned by reset in MEM
    run_instr(32'h00221820, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      ir = $urandom();
      e  = tbl[$urandom_range(0, 25)];
      ir[31:26] = e[11:6];
      if (e[11:6] == 6'h00) ir[5:0] = e[5:0];
      run_instr(ir, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the 32-bit cs147sec05 processor datapath.
- Steps each instruction through FETCH, DECODE, EXE, MEM and WB, and drives the datapath's 32-bit CTRL word.
- Drives the memory READ and WRITE strobes.
- Consumes the fetched instruction and the ALU ZERO flag; sits between the datapath and memory in the processor top level.

Parameters:
- CTRL_W, 32, control word width; bit map below.
- ILLEGAL_NOP, 1, 1: unknown opcode/funct executes as NOP (PC+1, no writes).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset, sampled on rising CLK.
- INSTRUCTION  in  32  memory read data; valid during FETCH.
- ZERO  in  1  ALU zero flag from the datapath.
- CTRL  out  32  datapath control word.
- READ  out  1  memory read strobe.
- WRITE  out  1  memory write strobe.

Behaviour:
- CTRL bit map:
  - 0 PC_LOAD; 3:1 PC_SEL_3..1; 4 IR_LOAD; 5 SP_LOAD; 6 REG_R; 7 REG_W; 8 OP1_SEL.
  - 12:9 OP2_SEL_4..1; 15:13 WD_SEL_3..1; 16 R1_SEL; 19:17 WA_SEL_3..1.
  - 21:20 MA_SEL_2..1; 22 MD_SEL; 25:23 reserved, always 0; 31:26 ALU_OPRN.
  - Every datapath mux passes its second input when its select is 1.
- State register: IDLE, FETCH, DECODE, EXE, MEM, WB.
  - Transitions: IDLE->FETCH->DECODE->EXE->MEM->WB->FETCH, one cycle each, unconditional. Every instruction takes 5 cycles.
- Reset: RST=1 at an edge puts state in IDLE, clears the internal IR copy and clears the branch flag.
  - In IDLE, CTRL=0, READ=0, WRITE=0.
  - Reset mid-instruction abandons it; no write strobe may assert in the cycle after reset.
- Outputs are a combinational decode of the state register, the internal IR copy and the branch flag. No output depends on INSTRUCTION directly.
- FETCH:
  - READ=1, MA_SEL_2=1 (address = PC), IR_LOAD=1.
  - The internal IR copy loads INSTRUCTION on the FETCH->DECODE edge.
- DECODE: REG_R=1; R1_SEL=1 for push, else 0.
- EXE:
  - REG_R=1; ALU_OPRN from opcode/funct.
  - ALU codes: add 01, sub 02, mul 03, shr 04, shl 05, and 06, or 07, nor 08, slt 09.
  - Operand 2 select:
    - R-type: OP2_SEL_4=1.
    - Shifts: OP2_SEL_4=0, OP2_SEL_3=1, OP2_SEL_1=1.
    - andi/ori: zero-extended immediate, OP2_SEL_2=0.
    - addi/muli/slti/lw/sw: sign-extended immediate, OP2_SEL_2=1.
    - beq/bne: sub on rs,rt.
  - push/pop: OP1_SEL=1 (SP), OP2 = constant 1 (OP2_SEL_3=1, OP2_SEL_1=0); push uses sub, pop uses add.
  - pop: SP_LOAD=1 in EXE.
  - Branch flag is registered on the EXE->MEM edge: beq takes ZERO, bne takes ~ZERO, all others 0.
- MEM: all ALU/operand selects are held from EXE.
  - lw: READ=1, MA_SEL_2=0, MA_SEL_1=0.
  - sw: WRITE=1, MD_SEL=0.
  - push: WRITE=1, MA_SEL_1=1, MD_SEL=1, R1_SEL=1.
  - pop: READ=1, MA_SEL_1=1.
  - READ and WRITE are never 1 together.
- WB: PC_LOAD=1 always.
  - PC source:
    - Default PC+1: PC_SEL_3=1, PC_SEL_2=0, PC_SEL_1=1.
    - Taken branch: PC_SEL_2=1.
    - jr: PC_SEL_1=0.
    - jmp/jal: PC_SEL_3=0.
  - REG_W=1 for R-type (except jr), addi/muli/andi/ori/slti/lui/lw/jal/pop.
  - Write address:
    - rd for R-type: WA_SEL_3=1, WA_SEL_1=0.
    - rt for I-type: WA_SEL_1=1.
    - r31 for jal: WA_SEL_3=0, WA_SEL_2=1.
    - r0 for pop: WA_SEL_2=0.
  - Write data:
    - ALU result: WD_SEL_3=1, WD_SEL_2=0, WD_SEL_1=0.
    - Memory data for lw/pop: WD_SEL_1=1.
    - lui: WD_SEL_2=1.
    - PC+1 for jal: WD_SEL_3=0.
  - push: SP_LOAD=1 in WB with SP-1 still selected.
- Illegal opcode or funct: no REG_W, WRITE or SP_LOAD; PC+1.

Decomposition:
- Shared project definition header holds:
  - opcode and funct constants;
  - ALU operation codes;
  - state encodings;
  - CTRL bit indices (CTRL_PC_LOAD ... CTRL_ALU_LSB).
- One sub-module, control_word_decode: combinational, takes (state, ir, br_flag) and produces (CTRL, READ, WRITE).
- control_unit keeps only the state register, the IR copy and the branch flag.

Test Plan:
- Reset sequencing: RST=1 for 2 edges, then 0 -> IDLE with CTRL=0; next edge enters FETCH with READ=1 and CTRL bits 4 and 21 set; the 5-cycle cycle repeats.
- add: INSTRUCTION=0x00221820 (add r3,r1,r2) -> EXE ALU_OPRN=01, OP2_SEL_4=1; WB REG_W=1, WA_SEL_3=1, WA_SEL_1=0, PC_LOAD=1.
- beq taken: beq with ZERO=1 at the EXE edge -> WB PC_SEL_2=1; with ZERO=0 -> PC_SEL_2=0 and PC_SEL_1=1.
- lw/sw/push: lw -> MEM READ=1, WRITE=0, MA_SEL_2=0. sw -> MEM WRITE=1, READ=0. push -> MEM WRITE=1, MA_SEL_1=1, MD_SEL=1; WB SP_LOAD=1, REG_W=0.
- jal: jal 0x0000100 -> WB PC_SEL_3=0, REG_W=1, WA_SEL_3=0, WA_SEL_2=1, WD_SEL_3=0.
- Reset during MEM of sw: RST=1 while state=MEM -> next cycle IDLE, WRITE=0; illegal opcode 0x3F -> no REG_W, WRITE or SP_LOAD in any phase.
